dbg_access_master: RTL and testbench
====================================

// Module: dbg_access_master
// PURPOSE
// - Initiator for the RI5CY debug-unit port (req/gnt/rvalid handshake).
// - Accepts single read/write commands on a host-side valid/ready channel
//   (from a JTAG or testbench bridge), runs the debug handshake and returns read data or an error.
// - Instantiated beside riscv_core in the top level: its debug_*_o outputs drive the core's
//   debug_*_i inputs, and its debug_*_i inputs take the core's debug_*_o outputs.
// PARAMETERS
// - ADDR_WIDTH  15   debug address width; equals the core's debug_addr_i width
// - DATA_WIDTH  32   debug data width
// - TIMEOUT     255  max cycles to wait for gnt, and separately for rvalid; 0 = wait forever
// PORTS
// - clk_i          in   1   clock
// - rstn_i         in   1   reset, synchronous, active-low
// - cmd_valid_i    in   1   host command valid
// - cmd_ready_o    out  1   command accepted when valid & ready
// - cmd_we_i       in   1   1 = write, 0 = read
// - cmd_addr_i     in   15  debug register address
// - cmd_wdata_i    in   32  write data
// - rsp_valid_o    out  1   response valid
// - rsp_ready_i    in   1   host accepts response
// - rsp_rdata_o    out  32  read data; 0 for writes and on error
// - rsp_err_o      out  1   1 = handshake timed out
// - debug_req_o    out  1   request to core
// - debug_gnt_i    in   1   core grant
// - debug_rvalid_i in   1   core response valid
// - debug_addr_o   out  15  address to core
// - debug_we_o     out  1   write enable to core
// - debug_wdata_o  out  32  write data to core
// - debug_rdata_i  in   32  read data from core
// - busy_o         out  1   state != IDLE
// BEHAVIOUR
// - Reset (rstn_i low at a rising edge):
//   - state <= IDLE; cmd regs, rsp_rdata_o, rsp_err_o, timeout count <= 0.
//   - All outputs are 0 except cmd_ready_o, which is 1.
// - Reset mid-operation: the pending command is dropped, no response is issued,
//   and debug_req_o is 0 from the next edge.
// - FSM states: IDLE, REQ, WAIT_RV, RESP.
//   - cmd_ready_o = (state == IDLE); busy_o = !cmd_ready_o.
// - IDLE:
//   - On cmd_valid_i: latch we/addr/wdata into the command regs, go to REQ.
//   - debug_req_o rises the cycle after acceptance.
// - REQ:
//   - debug_req_o = 1; debug_addr_o/we_o/wdata_o come from the command regs and stay stable.
//   - debug_gnt_i high (including the first REQ cycle) -> WAIT_RV; req is low the next cycle.
// - WAIT_RV:
//   - debug_req_o = 0.
//   - On debug_rvalid_i -> RESP, err = 0; rdata = debug_rdata_i for a read, 0 for a write.
//   - rvalid is expected for both reads and writes.
//   - rvalid outside WAIT_RV is ignored; the bench assertion flags it.
// - Timeout (TIMEOUT > 0):
//   - The counter clears on entry to REQ and to WAIT_RV, and increments each cycle spent there.
//   - If the awaited event is absent in the cycle where count == TIMEOUT-1 -> RESP, err = 1, rdata = 0.
//   - The awaited event on that final cycle still wins (normal completion).
//   - Counter width: $clog2(TIMEOUT+1).
// - RESP:
//   - rsp_valid_o = 1; rdata/err stay stable until rsp_ready_i, then IDLE.
// - Latency and throughput:
//   - Fastest case (accept at T, gnt at T+1, rvalid at T+2): rsp_valid_o at T+3.
//   - No overlap between commands; next accept is no earlier than the cycle after the response handshake.
// - debug_addr_o/we_o/wdata_o hold the last command values while IDLE.
// STRUCTURE
// - Package dbg_access_pkg:
//   - dbg_state_e {IDLE, REQ, WAIT_RV, RESP}
//   - DBG_ADDR_WIDTH = 15, DBG_DATA_WIDTH = 32
// - Single module with the timeout counter inline; no sub-module.
// TESTING
// 1. Write addr 0x2000, data 0xDEADBEEF; gnt in the first REQ cycle, rvalid next
//    -> req high 1 cycle with addr/we/wdata correct; rsp_valid_o at T+3, err = 0, rdata = 0.
// 2. Read with gnt delayed 5 cycles, rdata_i = 0x12345678 on rvalid
//    -> req high exactly 6 cycles; rsp_rdata_o = 0x12345678.
// 3. TIMEOUT = 4, gnt never arrives
//    -> req high exactly 4 cycles, then rsp_err_o = 1, rdata = 0.
// 4. TIMEOUT = 4, gnt, then rvalid on the 4th WAIT_RV cycle -> err = 0, data captured.
// 5. rsp_ready_i low for 10 cycles with cmd_valid_i held high
//    -> response stable, cmd_ready_o = 0, no second request until the handshake completes.
// 6. rstn_i low for 1 cycle while in REQ
//    -> next edge req = 0, busy = 0, rsp_valid = 0; TIMEOUT = 0 with gnt at cycle 1000 completes normally.

Source files
------------

// File: rtl/dbg_access_pkg.sv
// Shared types and widths for the debug-unit access master.
package dbg_access_pkg;

  localparam int DBG_ADDR_WIDTH = 15;
  localparam int DBG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RV,
    RESP
  } dbg_state_e;

endpackage

// File: rtl/dbg_access_master.sv
// Host-side single-command initiator for the core's debug port (req/gnt/rvalid).
// One command in flight; each handshake phase is bounded by TIMEOUT cycles (0 = unbounded).
module dbg_access_master
  import dbg_access_pkg::*;
#(
  parameter int ADDR_WIDTH = DBG_ADDR_WIDTH,
  parameter int DATA_WIDTH = DBG_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  debug_req_o,
  input  logic                  debug_gnt_i,
  input  logic                  debug_rvalid_i,
  output logic [ADDR_WIDTH-1:0] debug_addr_o,
  output logic                  debug_we_o,
  output logic [DATA_WIDTH-1:0] debug_wdata_o,
  input  logic [DATA_WIDTH-1:0] debug_rdata_i,
  output logic                  busy_o
);

  // A 1-bit counter is kept when TIMEOUT is 0; it never advances in that case.
  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  dbg_state_e            state;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [CW-1:0]         cnt;
  logic                  expired;

  // True on the last cycle allowed for the awaited event; the event itself still wins.
  assign expired = (TIMEOUT > 0) && (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_we    <= cmd_we_i;
            cmd_addr  <= cmd_addr_i;
            cmd_wdata <= cmd_wdata_i;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (debug_gnt_i) begin
            cnt   <= '0;
            state <= WAIT_RV;
          end else if (expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_RV: begin
          if (debug_rvalid_i) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= cmd_we ? '0 : debug_rdata_i;
            state     <= RESP;
          end else if (expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state == IDLE);
  assign busy_o        = !cmd_ready_o;
  assign debug_req_o   = (state == REQ);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_rdata_o   = rsp_rdata;
  assign rsp_err_o     = rsp_err;
  assign debug_addr_o  = cmd_addr;
  assign debug_we_o    = cmd_we;
  assign debug_wdata_o = cmd_wdata;

endmodule

// File: tb/tb_dbg_access_master.sv
// Two instances (TIMEOUT=4 and TIMEOUT=0) driven by directed and random traffic,
// checked every cycle against a transaction-level model.
module tb_dbg_access_master;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn[2], cmd_valid[2], cmd_we[2], rsp_ready[2], gnt[2], rvalid[2];
  logic [AW-1:0] cmd_addr[2];
  logic [DW-1:0] cmd_wdata[2], rdata_in[2];
  logic          cmd_ready[2], rsp_valid[2], rsp_err[2], dreq[2], dwe[2], busy[2];
  logic [DW-1:0] rsp_rdata[2], dwdata[2];
  logic [AW-1:0] daddr[2];

  dbg_access_master #(.TIMEOUT(4)) u_dut4 (
    .clk_i(clk), .rstn_i(rstn[0]), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
    .cmd_we_i(cmd_we[0]), .cmd_addr_i(cmd_addr[0]), .cmd_wdata_i(cmd_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .debug_req_o(dreq[0]), .debug_gnt_i(gnt[0]),
    .debug_rvalid_i(rvalid[0]), .debug_addr_o(daddr[0]), .debug_we_o(dwe[0]),
    .debug_wdata_o(dwdata[0]), .debug_rdata_i(rdata_in[0]), .busy_o(busy[0]));

  dbg_access_master #(.TIMEOUT(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn[1]), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
    .cmd_we_i(cmd_we[1]), .cmd_addr_i(cmd_addr[1]), .cmd_wdata_i(cmd_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .debug_req_o(dreq[1]), .debug_gnt_i(gnt[1]),
    .debug_rvalid_i(rvalid[1]), .debug_addr_o(daddr[1]), .debug_we_o(dwe[1]),
    .debug_wdata_o(dwdata[1]), .debug_rdata_i(rdata_in[1]), .busy_o(busy[1]));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction model: where the one in-flight command is, and how long it has waited.
  localparam int P_FREE = 0, P_ASK = 1, P_AWAIT = 2, P_ANSWER = 3;
  typedef struct {
    int            ph;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
    int            waited;
  } mdl_t;
  mdl_t m[2];

  function automatic void mstep(int k);
    int tmo;
    bit out_of_time;
    tmo = (k == 0) ? 4 : 0;
    if (!rstn[k]) begin
      m[k].ph = P_FREE; m[k].we = 1'b0; m[k].addr = '0; m[k].wdata = '0;
      m[k].rdata = '0; m[k].err = 1'b0; m[k].waited = 0;
      return;
    end
    out_of_time = (tmo != 0) && (m[k].waited + 1 >= tmo);
    case (m[k].ph)
      P_FREE: if (cmd_valid[k]) begin
        m[k].ph = P_ASK; m[k].we = cmd_we[k]; m[k].addr = cmd_addr[k];
        m[k].wdata = cmd_wdata[k]; m[k].waited = 0;
      end
      P_ASK: begin
        if (gnt[k]) begin m[k].ph = P_AWAIT; m[k].waited = 0; end
        else if (out_of_time) begin m[k].ph = P_ANSWER; m[k].err = 1'b1; m[k].rdata = '0; end
        else m[k].waited++;
      end
      P_AWAIT: begin
        if (rvalid[k]) begin
          m[k].ph = P_ANSWER; m[k].err = 1'b0;
          m[k].rdata = m[k].we ? '0 : rdata_in[k];
        end else if (out_of_time) begin m[k].ph = P_ANSWER; m[k].err = 1'b1; m[k].rdata = '0; end
        else m[k].waited++;
      end
      default: if (rsp_ready[k]) m[k].ph = P_FREE;
    endcase
  endfunction

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("cmd_ready", k, cmd_ready[k], m[k].ph == P_FREE);
        chk("busy", k, busy[k], m[k].ph != P_FREE);
        chk("debug_req", k, dreq[k], m[k].ph == P_ASK);
        chk("rsp_valid", k, rsp_valid[k], m[k].ph == P_ANSWER);
        chk("debug_addr", k, daddr[k], m[k].addr);
        chk("debug_we", k, dwe[k], m[k].we);
        chk("debug_wdata", k, dwdata[k], m[k].wdata);
        if (m[k].ph == P_ANSWER) begin
          chk("rsp_rdata", k, rsp_rdata[k], m[k].rdata);
          chk("rsp_err", k, rsp_err[k], m[k].err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(int k, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    cmd_valid[k] = 1'b1; cmd_we[k] = we; cmd_addr[k] = a; cmd_wdata[k] = d;
    tick();
    cmd_valid[k] = 1'b0;
    chk("accept_req", k, dreq[k], 1'b1);
  endtask

  // Counts cycles with req high, raising gnt on the gnt_at-th one (0 = never).
  task automatic count_req(int k, int gnt_at, int limit, output int n);
    n = 0;
    while (dreq[k] === 1'b1 && n < limit) begin
      n++;
      gnt[k] = (n == gnt_at);
      tick();
    end
    gnt[k] = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_we[k] = 1'b0; rsp_ready[k] = 1'b0;
      gnt[k] = 1'b0; rvalid[k] = 1'b0; cmd_addr[k] = '0; cmd_wdata[k] = '0; rdata_in[k] = '0;
    end
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd_ready", k, cmd_ready[k], 1'b1);
      chk("rst_busy", k, busy[k], 1'b0);
      chk("rst_req", k, dreq[k], 1'b0);
      chk("rst_rsp_valid", k, rsp_valid[k], 1'b0);
      chk("rst_rdata", k, rsp_rdata[k], 32'h0);
      chk("rst_err", k, rsp_err[k], 1'b0);
      chk("rst_addr", k, daddr[k], 15'h0);
      chk("rst_wdata", k, dwdata[k], 32'h0);
      rstn[k] = 1'b1; rsp_ready[k] = 1'b1;
    end
    chk_en = 1'b1;
    tick();

    // Fastest write: gnt on first REQ cycle, rvalid next; response three cycles after accept.
    accept(0, 1'b1, 15'h2000, 32'hDEADBEEF);
    chk("t1_addr", 0, daddr[0], 15'h2000);
    chk("t1_we", 0, dwe[0], 1'b1);
    chk("t1_wdata", 0, dwdata[0], 32'hDEADBEEF);
    gnt[0] = 1'b1; tick(); gnt[0] = 1'b0;
    chk("t1_req_low", 0, dreq[0], 1'b0);
    chk("t1_rsp_early", 0, rsp_valid[0], 1'b0);
    rvalid[0] = 1'b1; rdata_in[0] = 32'hFFFFFFFF; tick(); rvalid[0] = 1'b0;
    chk("t1_rsp_valid", 0, rsp_valid[0], 1'b1);
    chk("t1_err", 0, rsp_err[0], 1'b0);
    chk("t1_rdata", 0, rsp_rdata[0], 32'h0);
    tick();
    chk("t1_idle", 0, cmd_ready[0], 1'b1);

    // Read with gnt on the 6th REQ cycle.
    accept(1, 1'b0, 15'h0010, 32'h0);
    count_req(1, 6, 50, n);
    chk("t2_req_cycles", 1, n, 6);
    rvalid[1] = 1'b1; rdata_in[1] = 32'h12345678; tick(); rvalid[1] = 1'b0;
    chk("t2_rdata", 1, rsp_rdata[1], 32'h12345678);
    chk("t2_err", 1, rsp_err[1], 1'b0);
    tick();

    // gnt never arrives with TIMEOUT=4.
    accept(0, 1'b0, 15'h0123, 32'h0);
    count_req(0, 0, 50, n);
    chk("t3_req_cycles", 0, n, 4);
    chk("t3_rsp_valid", 0, rsp_valid[0], 1'b1);
    chk("t3_err", 0, rsp_err[0], 1'b1);
    chk("t3_rdata", 0, rsp_rdata[0], 32'h0);
    tick();

    // rvalid on the last permitted WAIT_RV cycle still completes normally.
    accept(0, 1'b0, 15'h0456, 32'h0);
    gnt[0] = 1'b1; tick(); gnt[0] = 1'b0;
    repeat (3) tick();
    chk("t4_not_yet", 0, rsp_valid[0], 1'b0);
    rvalid[0] = 1'b1; rdata_in[0] = 32'hCAFEF00D; tick(); rvalid[0] = 1'b0;
    chk("t4_rsp_valid", 0, rsp_valid[0], 1'b1);
    chk("t4_err", 0, rsp_err[0], 1'b0);
    chk("t4_rdata", 0, rsp_rdata[0], 32'hCAFEF00D);
    tick();

    // Response back-pressure with a new command waiting.
    rsp_ready[0] = 1'b0;
    cmd_valid[0] = 1'b1; cmd_we[0] = 1'b1; cmd_addr[0] = 15'h0777; cmd_wdata[0] = 32'h55AA55AA;
    tick();
    gnt[0] = 1'b1; tick(); gnt[0] = 1'b0;
    rvalid[0] = 1'b1; rdata_in[0] = 32'h0BADF00D; tick(); rvalid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", 0, rsp_valid[0], 1'b1);
      chk("t5_hold_rdata", 0, rsp_rdata[0], 32'h0);
      chk("t5_no_ready", 0, cmd_ready[0], 1'b0);
      chk("t5_no_req", 0, dreq[0], 1'b0);
      tick();
    end
    rsp_ready[0] = 1'b1; tick();
    chk("t5_after_hs_ready", 0, cmd_ready[0], 1'b1);
    chk("t5_after_hs_valid", 0, rsp_valid[0], 1'b0);
    cmd_addr[0] = 15'h0778; tick(); cmd_valid[0] = 1'b0;
    chk("t5_second_req", 0, dreq[0], 1'b1);
    chk("t5_second_addr", 0, daddr[0], 15'h0778);
    gnt[0] = 1'b1; tick(); gnt[0] = 1'b0;
    rvalid[0] = 1'b1; tick(); rvalid[0] = 1'b0;
    tick();

    // Reset during REQ drops the command.
    accept(0, 1'b0, 15'h0100, 32'h0);
    rstn[0] = 1'b0; tick(); rstn[0] = 1'b1;
    chk("t6_req", 0, dreq[0], 1'b0);
    chk("t6_busy", 0, busy[0], 1'b0);
    chk("t6_rsp_valid", 0, rsp_valid[0], 1'b0);

    // TIMEOUT=0 waits as long as it takes.
    accept(1, 1'b1, 15'h0200, 32'h1);
    count_req(1, 1000, 1100, n);
    chk("t6_long_req_cycles", 1, n, 1000);
    rvalid[1] = 1'b1; tick(); rvalid[1] = 1'b0;
    chk("t6_long_rsp_valid", 1, rsp_valid[1], 1'b1);
    chk("t6_long_err", 1, rsp_err[1], 1'b0);
    tick();

    // Random traffic; gnt/rvalid only offered while the model is waiting for them.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rstn[k]      = ($urandom_range(199, 0) != 0);
        cmd_valid[k] = $urandom_range(1, 0);
        cmd_we[k]    = $urandom_range(1, 0);
        cmd_addr[k]  = AW'($urandom);
        cmd_wdata[k] = $urandom;
        rdata_in[k]  = $urandom;
        rsp_ready[k] = $urandom_range(1, 0);
        gnt[k]       = (m[k].ph == P_ASK) && ($urandom_range(9, 0) < 3);
        rvalid[k]    = (m[k].ph == P_AWAIT) && ($urandom_range(9, 0) < 3);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
